pipe_rr_sched: RTL and testbench

- Round-robin scheduler that shares one external 3-stage arithmetic pipeline among NREQ requesters. The pipeline computes f = ((a+b)+(c-d))*d, truncated to W bits.
- Accepts at most one operation per clock and drives the operands into the pipeline.
- Tracks each in-flight operation's requester ID through a LAT-deep tag shift register.
- Returns each result with the requester ID that issued it.
- Sits between the requester clients and the shared pipeline.

---
 rtl/pipe_rr_sched.sv | 83 ++++++++
 tb/tb_pipe_rr_sched.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_rr_sched.sv
// pipe_rr_sched: round-robin issue into a shared fixed-latency pipeline with in-order result tagging
module pipe_rr_sched #(
  parameter int W = 10,
  parameter int NREQ = 4,
  parameter int LAT = 4,
  localparam int IDW = $clog2(NREQ),
  localparam int CW = $clog2(LAT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*W-1:0] req_c,
  input  logic [NREQ*W-1:0] req_d,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      p_a,
  output logic [W-1:0]      p_b,
  output logic [W-1:0]      p_c,
  output logic [W-1:0]      p_d,
  output logic              p_valid,
  input  logic [W-1:0]      p_f,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_f,
  output logic [CW-1:0]     inflight
);
  logic [IDW-1:0] ptr, gnt_id;
  logic gnt;
  int idx;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0][IDW-1:0] tag_id;
  always_comb begin
    gnt = 1'b0;
    gnt_id = '0;
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && req_valid[idx]) begin
        gnt = 1'b1;
        gnt_id = idx[IDW-1:0];
      end
    end
  end
  assign req_ready = {{(NREQ-1){1'b0}}, gnt} << gnt_id;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_a <= '0;
      p_b <= '0;
      p_c <= '0;
      p_d <= '0;
      p_valid <= 1'b0;
      ptr <= '0;
      tag_v <= '0;
      tag_id <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_f <= '0;
      inflight <= '0;
    end else begin
      p_valid <= gnt;
      if (gnt) begin
        p_a <= req_a[int'(gnt_id)*W +: W];
        p_b <= req_b[int'(gnt_id)*W +: W];
        p_c <= req_c[int'(gnt_id)*W +: W];
        p_d <= req_d[int'(gnt_id)*W +: W];
        ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
      tag_v <= {tag_v[LAT-2:0], gnt};
      tag_id <= {tag_id[LAT-2:0], gnt_id};
      resp_valid <= tag_v[LAT-1];
      if (tag_v[LAT-1]) begin
        resp_id <= tag_id[LAT-1];
        resp_f <= p_f;
      end
      if (gnt && !tag_v[LAT-1])
        inflight <= inflight + 1'b1;
      else if (!gnt && tag_v[LAT-1])
        inflight <= inflight - 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_rr_sched.sv
// tb_pipe_rr_sched: directed table plus randomized scoreboard checks for pipe_rr_sched
module tb_pipe_rr_sched;
  localparam int W = 10, NREQ = 4, LAT = 4, IDW = 2, CW = 3;
  logic clk = 0, rst = 0, en = 0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*W-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
  logic [W-1:0] p_a, p_b, p_c, p_d, resp_f;
  logic [W-1:0] p_f = '0;
  logic p_valid, resp_valid;
  logic [IDW-1:0] resp_id;
  logic [CW-1:0] inflight;

  pipe_rr_sched #(.W(W), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
    .req_ready(req_ready), .p_a(p_a), .p_b(p_b), .p_c(p_c), .p_d(p_d),
    .p_valid(p_valid), .p_f(p_f), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_f(resp_f), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // Shared pipeline: operands captured at E+1, f produced at E+3; it is never reset.
  logic [W-1:0] s1a = '0, s1b = '0, s1c = '0, s1d = '0, s2x = '0, s2d = '0;
  always @(posedge clk) begin
    s1a <= p_a;
    s1b <= p_b;
    s1c <= p_c;
    s1d <= p_d;
    s2x <= (s1a + s1b) + (s1c - s1d);
    s2d <= s1d;
    p_f <= s2x * s2d;
  end

  typedef struct {
    int id;
    int due;
    logic [W-1:0] a, b, c, d, f;
  } exp_t;
  exp_t q[$];
  int mptr = 0, cyc = 0, checks = 0, errors = 0;

  typedef struct {
    bit rst, en;
    logic [NREQ-1:0] rv;
    logic [W-1:0] a, b, c, d;
    logic [NREQ-1:0] ready;
    bit ov;
    int oid, of;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [W-1:0] fref(int a, int b, int c, int d);
    int r;
    r = ((a + b) + (c - d)) * d;
    return W'(r);
  endfunction

  function automatic void add(bit r, bit e, logic [NREQ-1:0] v, int a, int b, int c, int d,
                              logic [NREQ-1:0] rd, bit ov = 0, int oid = 0, int of = 0);
    vec_t t;
    t.rst = r; t.en = e; t.rv = v;
    t.a = W'(a); t.b = W'(b); t.c = W'(c); t.d = W'(d);
    t.ready = rd; t.ov = ov; t.oid = oid; t.of = of;
    tbl.push_back(t);
  endfunction

  function automatic void idle(bit ov = 0, int oid = 0, int of = 0);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, ov, oid, of);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset;
    rst = 1;
    en = 0;
    req_valid = '0;
    #1;
    chk("rst_p_valid", p_valid, 0);
    chk("rst_p_ops", {p_a, p_b, p_c, p_d}, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_f", resp_f, 0);
    chk("rst_inflight", inflight, 0);
    q.delete();
    mptr = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Drives one cycle starting just after an edge; returns the grant seen before the edge.
  task automatic step(input logic e, input logic [NREQ-1:0] rv,
                      input logic [NREQ*W-1:0] a, input logic [NREQ*W-1:0] b,
                      input logic [NREQ*W-1:0] c, input logic [NREQ*W-1:0] d,
                      output logic [NREQ-1:0] rdy);
    int g, j;
    logic [NREQ-1:0] er;
    exp_t t;
    en = e; req_valid = rv; req_a = a; req_b = b; req_c = c; req_d = d;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (mptr + k) % NREQ;
      if (e && g < 0 && rv[j]) g = j;
    end
    er = (g < 0) ? '0 : NREQ'(1) << g;
    rdy = req_ready;
    chk("req_ready", req_ready, er);
    if (g >= 0) begin
      t.id = g;
      t.a = a[g*W +: W]; t.b = b[g*W +: W]; t.c = c[g*W +: W]; t.d = d[g*W +: W];
      t.f = fref(t.a, t.b, t.c, t.d);
      t.due = cyc + 1 + LAT;
      q.push_back(t);
      mptr = (g + 1) % NREQ;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("p_valid", p_valid, g >= 0);
    if (g >= 0) chk("p_ops", {p_a, p_b, p_c, p_d}, {t.a, t.b, t.c, t.d});
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("resp_valid", resp_valid, 1);
      chk("resp_id", resp_id, q[0].id);
      chk("resp_f", resp_f, q[0].f);
      void'(q.pop_front());
    end else chk("resp_valid", resp_valid, 0);
    chk("inflight", inflight, q.size());
  endtask

  initial begin
    logic [NREQ-1:0] rdy;
    logic [NREQ*W-1:0] ra, rb, rc, rd;
    // single request
    add(1, 1, 4'b0001, 10, 20, 30, 20, 4'b0001);
    idle(); idle(); idle(); idle(1, 0, 800);
    // back-to-back from requester 2
    add(0, 1, 4'b0100, 10, 20, 30, 20, 4'b0100);
    add(0, 1, 4'b0100, 5, 15, 25, 10, 4'b0100);
    add(0, 1, 4'b0100, 1, 2, 4, 3, 4'b0100);
    idle(); idle(1, 2, 800); idle(1, 2, 350); idle(1, 2, 12);
    // fairness from reset
    add(1, 1, 4'b1111, 10, 20, 30, 20, 4'b0001);
    add(0, 1, 4'b1111, 10, 20, 30, 20, 4'b0010);
    add(0, 1, 4'b1111, 10, 20, 30, 20, 4'b0100);
    add(0, 1, 4'b1111, 10, 20, 30, 20, 4'b1000);
    add(0, 1, 4'b1111, 10, 20, 30, 20, 4'b0001, 1, 0, 800);
    add(0, 1, 4'b1111, 10, 20, 30, 20, 4'b0010, 1, 1, 800);
    add(0, 1, 4'b1111, 10, 20, 30, 20, 4'b0100, 1, 2, 800);
    add(0, 1, 4'b1111, 10, 20, 30, 20, 4'b1000, 1, 3, 800);
    idle(1, 0, 800); idle(1, 1, 800); idle(1, 2, 800); idle(1, 3, 800);
    // pointer wrap between requesters 3 and 1
    add(0, 1, 4'b1000, 1, 2, 4, 3, 4'b1000);
    add(0, 1, 4'b1010, 1, 2, 4, 3, 4'b0010);
    add(0, 1, 4'b1010, 1, 2, 4, 3, 4'b1000);
    add(0, 1, 4'b1010, 1, 2, 4, 3, 4'b0010);
    idle(1, 3, 12); idle(1, 1, 12); idle(1, 3, 12); idle(1, 1, 12);
    // en gating while a result drains
    add(0, 1, 4'b1111, 5, 15, 25, 10, 4'b0100);
    add(0, 0, 4'b1111, 5, 15, 25, 10, 4'b0000);
    add(0, 0, 4'b1111, 5, 15, 25, 10, 4'b0000);
    add(0, 0, 4'b1111, 5, 15, 25, 10, 4'b0000);
    add(0, 0, 4'b1111, 5, 15, 25, 10, 4'b0000, 1, 2, 350);
    add(0, 1, 4'b0001, 5, 15, 25, 10, 4'b0001);
    idle(); idle(); idle(); idle(1, 0, 350);
    // modular overflow
    add(0, 1, 4'b0001, 1023, 1, 0, 0, 4'b0001);
    idle(); idle(); idle(); idle(1, 0, 0);

    #6;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].en, tbl[i].rv, {NREQ{tbl[i].a}}, {NREQ{tbl[i].b}},
           {NREQ{tbl[i].c}}, {NREQ{tbl[i].d}}, rdy);
      chk("tbl_ready", rdy, tbl[i].ready);
      chk("tbl_resp_valid", resp_valid, tbl[i].ov);
      if (tbl[i].ov) begin
        chk("tbl_resp_id", resp_id, tbl[i].oid);
        chk("tbl_resp_f", resp_f, tbl[i].of);
      end
    end

    // reset two cycles after issuing two operations: their results must vanish
    ra = {10'd4, 10'd3, 10'd2, 10'd1};
    step(1, 4'b0011, ra, ra, ra, ra, rdy);
    step(1, 4'b0011, ra, ra, ra, ra, rdy);
    step(1, 4'b0000, ra, ra, ra, ra, rdy);
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 4'b0000, ra, ra, ra, ra, rdy);

    // randomized traffic against the scoreboard
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      step($urandom_range(0, 7) != 0, NREQ'($urandom), ra, rb, rc, rd, rdy);
    end
    for (int i = 0; i < LAT + 1; i++) step(0, 4'b0000, ra, rb, rc, rd, rdy);
    chk("drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
